// File: rtl/hybrid_boot_sequencer.sv
// Boot and partial-reconfiguration sequencer for the hybrid RISC-V + CGRA system.
// It drives the configurator, CGRA and core reset/enable lines from one on-chip FSM.
module hybrid_boot_sequencer #(
    parameter int NUM_CGRA     = 1,
    parameter int RESET_CYCLES = 4,
    parameter int CFG_TIMEOUT  = 1024,
    parameter int CNT_W        = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                reconfig_req_i,
    input  logic [NUM_CGRA-1:0] cgra_sel_i,
    input  logic [NUM_CGRA-1:0] cfg_done_i,
    output logic                cfg_clk_en_o,
    output logic                cfg_reset_o,
    output logic [NUM_CGRA-1:0] configurator_reset_o,
    output logic [NUM_CGRA-1:0] configurator_enable_o,
    output logic [NUM_CGRA-1:0] cgra_clk_en_o,
    output logic [NUM_CGRA-1:0] cgra_reset_o,
    output logic                core_rst_no,
    output logic                core_enable_o,
    output logic                busy_o,
    output logic                error_o,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG_RST = 3'd1,
        S_CFG_RUN = 3'd2,
        S_RUN_RST = 3'd3,
        S_RUN     = 3'd4,
        S_ERROR   = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = (CFG_TIMEOUT > 0) ? CNT_W'(CFG_TIMEOUT - 1) : '0;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [NUM_CGRA-1:0] sel_q, sel_d, done_q, done_d;
    logic                booted_q, booted_d;
    logic                accept, all_done;

    logic                cfg_clk_en_d, cfg_reset_d, core_rst_n_d, core_enable_d, busy_d, error_d;
    logic [NUM_CGRA-1:0] cfgr_reset_d, cfgr_enable_d, cgra_clk_en_d, cgra_reset_d;

    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign all_done = ((done_q | cfg_done_i) & sel_q) == sel_q;
    assign state_o  = state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        sel_d    = sel_q;
        done_d   = done_q;
        booted_d = booted_q;
        accept   = 1'b0;
        unique case (state_q)
            S_IDLE, S_ERROR: accept = start_i;
            S_CFG_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_CFG_RUN;
                    cnt_d   = '0;
                    done_d  = '0;
                end
            end
            S_CFG_RUN: begin
                done_d = done_q | (cfg_done_i & sel_q);
                // completion is tested first so it wins over a coincident timeout
                if (all_done) begin
                    state_d = S_RUN_RST;
                    cnt_d   = '0;
                end else if (CFG_TIMEOUT != 0 && cnt_q >= TO_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_RUN_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN:   accept = reconfig_req_i;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            sel_d   = cgra_sel_i;
            cnt_d   = '0;
            state_d = (cgra_sel_i == '0) ? S_RUN_RST : S_CFG_RST;
        end
        if (state_d == S_RUN) booted_d = 1'b1;
    end

    // Outputs are registered from the next state so they line up with state_o.
    always_comb begin
        cfg_clk_en_d  = cfg_clk_en_o;
        cfg_reset_d   = cfg_reset_o;
        cfgr_reset_d  = configurator_reset_o;
        cfgr_enable_d = configurator_enable_o;
        cgra_clk_en_d = cgra_clk_en_o;
        cgra_reset_d  = cgra_reset_o;
        core_rst_n_d  = core_rst_no;
        core_enable_d = core_enable_o;
        busy_d        = 1'b0;
        error_d       = error_o;
        unique case (state_d)
            S_CFG_RST: begin
                cfg_clk_en_d  = 1'b1;
                cfg_reset_d   = 1'b1;
                cfgr_reset_d  = configurator_reset_o | sel_d;
                cfgr_enable_d = '0;
                cgra_clk_en_d = cgra_clk_en_o & ~sel_d;
                core_enable_d = 1'b0;
                busy_d        = 1'b1;
                error_d       = 1'b0;
            end
            S_CFG_RUN: begin
                cfg_clk_en_d  = 1'b1;
                cfg_reset_d   = 1'b0;
                cfgr_reset_d  = configurator_reset_o & ~sel_d;
                cfgr_enable_d = sel_d;
                core_enable_d = 1'b0;
                busy_d        = 1'b1;
            end
            S_RUN_RST: begin
                cfg_clk_en_d  = 1'b0;
                cfgr_enable_d = '0;
                cgra_clk_en_d = cgra_clk_en_o | sel_d;
                cgra_reset_d  = cgra_reset_o | sel_d;
                core_rst_n_d  = booted_q;
                core_enable_d = 1'b0;
                busy_d        = 1'b1;
                error_d       = 1'b0;
            end
            S_RUN: begin
                cgra_reset_d  = cgra_reset_o & ~sel_d;
                core_rst_n_d  = 1'b1;
                core_enable_d = 1'b1;
            end
            S_ERROR: begin
                error_d       = 1'b1;
                cfg_clk_en_d  = 1'b0;
                cfgr_enable_d = '0;
                cfgr_reset_d  = '1;
                core_enable_d = 1'b0;
                core_rst_n_d  = booted_q;
            end
            default: begin
                cfg_clk_en_d  = 1'b0;
                cfg_reset_d   = 1'b1;
                cfgr_reset_d  = '1;
                cfgr_enable_d = '0;
                cgra_clk_en_d = '0;
                cgra_reset_d  = '1;
                core_rst_n_d  = 1'b0;
                core_enable_d = 1'b0;
                error_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q               <= S_IDLE;
            cnt_q                 <= '0;
            sel_q                 <= '0;
            done_q                <= '0;
            booted_q              <= 1'b0;
            cfg_clk_en_o          <= 1'b0;
            cfg_reset_o           <= 1'b1;
            configurator_reset_o  <= '1;
            configurator_enable_o <= '0;
            cgra_clk_en_o         <= '0;
            cgra_reset_o          <= '1;
            core_rst_no           <= 1'b0;
            core_enable_o         <= 1'b0;
            busy_o                <= 1'b0;
            error_o               <= 1'b0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            sel_q                 <= sel_d;
            done_q                <= done_d;
            booted_q              <= booted_d;
            cfg_clk_en_o          <= cfg_clk_en_d;
            cfg_reset_o           <= cfg_reset_d;
            configurator_reset_o  <= cfgr_reset_d;
            configurator_enable_o <= cfgr_enable_d;
            cgra_clk_en_o         <= cgra_clk_en_d;
            cgra_reset_o          <= cgra_reset_d;
            core_rst_no           <= core_rst_n_d;
            core_enable_o         <= core_enable_d;
            busy_o                <= busy_d;
            error_o               <= error_d;
        end
    end

endmodule

// File: tb/tb_hybrid_boot_sequencer.sv
// Bench for hybrid_boot_sequencer: per-request phase traces predicted from done schedules.
module tb_hybrid_boot_sequencer;

    localparam int N = 2;
    localparam int R = 4;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         reconfig_req_i = 1'b0;
    logic [N-1:0] cgra_sel_i = '0;
    logic [N-1:0] cfg_done_i = '0;
    logic         cfg_clk_en_o, cfg_reset_o, core_rst_no, core_enable_o, busy_o, error_o;
    logic [N-1:0] configurator_reset_o, configurator_enable_o, cgra_clk_en_o, cgra_reset_o;
    logic [2:0]   state_o;

    int n_cmp = 0;
    int n_bad = 0;

    // transaction-level model of what is visible between requests
    logic [N-1:0] m_clk_en, m_cgra_rst;
    bit           m_booted, m_err;
    int           m_state;

    hybrid_boot_sequencer #(
        .NUM_CGRA(N), .RESET_CYCLES(R), .CFG_TIMEOUT(T), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .reconfig_req_i(reconfig_req_i),
        .cgra_sel_i(cgra_sel_i), .cfg_done_i(cfg_done_i), .cfg_clk_en_o(cfg_clk_en_o),
        .cfg_reset_o(cfg_reset_o), .configurator_reset_o(configurator_reset_o),
        .configurator_enable_o(configurator_enable_o), .cgra_clk_en_o(cgra_clk_en_o),
        .cgra_reset_o(cgra_reset_o), .core_rst_no(core_rst_no), .core_enable_o(core_enable_o),
        .busy_o(busy_o), .error_o(error_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_ni = 1'b0; start_i = 1'b0; reconfig_req_i = 1'b0; cgra_sel_i = '0; cfg_done_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        m_clk_en = '0; m_cgra_rst = '1; m_booted = 0; m_err = 0; m_state = 0;
    endtask

    task automatic test_reset();
        logic [31:0] got, want;
        apply_reset();
        @(negedge clk);
        got  = {cfg_clk_en_o, cfg_reset_o, configurator_reset_o, configurator_enable_o,
                cgra_clk_en_o, cgra_reset_o, core_rst_no, core_enable_o, busy_o, error_o, state_o};
        want = {1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL reset_values: got %h want %h", got, want);
        end
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_bad++; $display("FAIL reset_state: got %0d want 0", state_o);
        end
    endtask

    // Issues one request and follows the predicted state trace cycle by cycle.
    task automatic run_request(input bit use_start, input bit use_reconf, input logic [1:0] sel,
                               input int da0, input int da1, input bit p0, input bit p1,
                               input string tag);
        int q[$];
        int da[2];
        bit pl[2];
        int ncomp, fin, k;
        bit accepted;
        logic [1:0] drv;
        da[0] = da0; da[1] = da1; pl[0] = p0; pl[1] = p1;
        accepted = (use_start && (m_state == 0 || m_state == 5)) || (use_reconf && m_state == 4);
        fin = m_state;
        if (accepted) begin
            if (sel == 2'b00) begin
                repeat (R) q.push_back(3);
                fin = 4;
            end else begin
                ncomp = 0;
                for (int b = 0; b < N; b++)
                    if (sel[b]) begin
                        if (da[b] < 0) ncomp = -1;
                        else if (ncomp >= 0 && da[b] > ncomp) ncomp = da[b];
                    end
                repeat (R) q.push_back(1);
                if (ncomp >= 0 && ncomp < T) begin
                    repeat (ncomp + 1) q.push_back(2);
                    repeat (R) q.push_back(3);
                    fin = 4;
                end else begin
                    repeat (T) q.push_back(2);
                    fin = 5;
                end
            end
        end
        @(negedge clk);
        start_i = use_start; reconfig_req_i = use_reconf; cgra_sel_i = sel;
        cfg_done_i = 2'($urandom);
        @(posedge clk); #1;
        start_i = 1'b0; reconfig_req_i = 1'b0; cgra_sel_i = 2'($urandom);
        for (int c = 0; c < q.size(); c++) begin
            k = c - R;
            for (int b = 0; b < N; b++)
                if (sel[b] && k >= 0)
                    drv[b] = (da[b] >= 0) && (pl[b] ? (k == da[b]) : (k >= da[b]));
                else
                    drv[b] = 1'($urandom_range(0, 1));
            cfg_done_i = drv;
            @(negedge clk);
            n_cmp++;
            if (state_o !== 3'(q[c])) begin
                n_bad++; $display("FAIL %s state c=%0d: got %0d want %0d", tag, c, state_o, q[c]);
            end
            n_cmp++;
            if ({busy_o, core_enable_o, core_rst_no} !== {1'b1, 1'b0, m_booted}) begin
                n_bad++; $display("FAIL %s busy/core c=%0d: got %b want %b", tag, c,
                                  {busy_o, core_enable_o, core_rst_no}, {1'b1, 1'b0, m_booted});
            end
            n_cmp++;
            if (cfg_clk_en_o !== (q[c] != 3)) begin
                n_bad++; $display("FAIL %s cfg_clk_en c=%0d: got %b want %b", tag, c,
                                  cfg_clk_en_o, q[c] != 3);
            end
            if (q[c] == 1 || q[c] == 2) begin
                n_cmp++;
                if (cgra_clk_en_o !== (m_clk_en & ~sel)) begin
                    n_bad++; $display("FAIL %s cgra_clk_en_cfg c=%0d: got %b want %b", tag, c,
                                      cgra_clk_en_o, m_clk_en & ~sel);
                end
            end
            if (q[c] == 2) begin
                n_cmp++;
                if (configurator_enable_o !== sel) begin
                    n_bad++; $display("FAIL %s cfgr_enable c=%0d: got %b want %b", tag, c,
                                      configurator_enable_o, sel);
                end
            end
            if (q[c] == 3) begin
                n_cmp++;
                if ({cgra_reset_o, cgra_clk_en_o} !== {m_cgra_rst | sel, m_clk_en | sel}) begin
                    n_bad++; $display("FAIL %s run_rst_arrays c=%0d: got %b want %b", tag, c,
                                      {cgra_reset_o, cgra_clk_en_o}, {m_cgra_rst | sel, m_clk_en | sel});
                end
            end
            @(posedge clk); #1;
        end
        if (accepted) begin
            if (fin == 4) begin
                m_clk_en = m_clk_en | sel; m_cgra_rst = m_cgra_rst & ~sel;
                m_booted = 1; m_err = 0;
            end else begin
                m_clk_en = m_clk_en & ~sel; m_err = 1;
            end
            m_state = fin;
        end
        @(negedge clk);
        n_cmp++;
        if (state_o !== 3'(m_state)) begin
            n_bad++; $display("FAIL %s final_state: got %0d want %0d", tag, state_o, m_state);
        end
        n_cmp++;
        if ({error_o, busy_o, core_enable_o, core_rst_no} !==
            {m_err, 1'b0, m_state == 4, (m_state == 4) | m_booted}) begin
            n_bad++; $display("FAIL %s final_ctrl: got %b want %b", tag,
                              {error_o, busy_o, core_enable_o, core_rst_no},
                              {m_err, 1'b0, m_state == 4, (m_state == 4) | m_booted});
        end
        n_cmp++;
        if ({cgra_clk_en_o, cgra_reset_o} !== {m_clk_en, m_cgra_rst}) begin
            n_bad++; $display("FAIL %s final_arrays: got %b want %b", tag,
                              {cgra_clk_en_o, cgra_reset_o}, {m_clk_en, m_cgra_rst});
        end
        if (m_state == 5) begin
            n_cmp++;
            if ({configurator_reset_o, configurator_enable_o, cfg_clk_en_o} !== 5'b11000) begin
                n_bad++; $display("FAIL %s error_cfg: got %b want 11000", tag,
                                  {configurator_reset_o, configurator_enable_o, cfg_clk_en_o});
            end
        end
    endtask

    task automatic test_cold_boot();
        apply_reset();
        run_request(1, 0, 2'b11, 3, 3, 0, 0, "cold_boot");
    endtask

    task automatic test_partial_reconfig();
        run_request(0, 1, 2'b10, 2, 5, 0, 0, "partial_reconfig");
    endtask

    task automatic test_ignored_requests();
        apply_reset();
        run_request(0, 1, 2'b11, 0, 0, 0, 0, "reconfig_in_idle");
        run_request(1, 0, 2'b00, -1, -1, 0, 0, "empty_mask_boot");
        run_request(1, 0, 2'b11, 0, 0, 0, 0, "start_in_run");
        run_request(1, 1, 2'b01, 1, 9, 0, 0, "start_and_reconfig");
        run_request(0, 1, 2'b00, -1, -1, 0, 0, "empty_reconfig");
    endtask

    task automatic test_staggered_done();
        apply_reset();
        run_request(1, 0, 2'b11, 1, 6, 1, 0, "staggered_done");
    endtask

    task automatic test_timeout();
        apply_reset();
        run_request(1, 0, 2'b11, 0, -1, 0, 0, "timeout_cold");
        run_request(1, 0, 2'b11, 0, 0, 0, 0, "recover_boot");
        run_request(0, 1, 2'b01, T - 1, -1, 0, 0, "done_at_timeout_edge");
        run_request(0, 1, 2'b01, T, -1, 0, 0, "done_after_timeout");
        run_request(1, 0, 2'b01, 0, -1, 0, 0, "recover_after_reconfig_err");
    endtask

    task automatic test_async_reset();
        logic [31:0] got, want;
        apply_reset();
        @(negedge clk);
        start_i = 1'b1; cgra_sel_i = 2'b11; cfg_done_i = 2'b00;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (R + 2) @(posedge clk);
        #2;
        n_cmp++;
        if (state_o !== 3'd2) begin
            n_bad++; $display("FAIL async_pre_state: got %0d want 2", state_o);
        end
        rst_ni = 1'b0;
        #1;
        got  = {cfg_clk_en_o, cfg_reset_o, configurator_reset_o, configurator_enable_o,
                cgra_clk_en_o, cgra_reset_o, core_rst_no, core_enable_o, busy_o, error_o, state_o};
        want = {1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        n_cmp++;
        if (got !== want) begin
            n_bad++; $display("FAIL async_reset_values: got %h want %h", got, want);
        end
        apply_reset();
        run_request(1, 0, 2'b01, 0, -1, 0, 0, "boot_after_async_reset");
    endtask

    task automatic test_random();
        logic [1:0] sel;
        int d0, d1;
        bit p0, p1;
        for (int i = 0; i < 30; i++) begin
            sel = 2'($urandom);
            d0 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 18));
            d1 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 18));
            p0 = 1'($urandom_range(0, 1));
            p1 = 1'($urandom_range(0, 1));
            if (m_state == 4) begin
                case ($urandom_range(0, 3))
                    0:       run_request(1, 0, sel, d0, d1, p0, p1, "rand_start_in_run");
                    1:       run_request(1, 1, sel, d0, d1, p0, p1, "rand_both_in_run");
                    default: run_request(0, 1, sel, d0, d1, p0, p1, "rand_reconfig");
                endcase
            end else begin
                run_request(1, 1'($urandom_range(0, 1)), sel, d0, d1, p0, p1, "rand_start");
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_boot();
        test_partial_reconfig();
        test_ignored_requests();
        test_staggered_done();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
